// File: rtl/mac_dot_seq_pkg.sv
// Shared types and constants for the sequenced dot-product MAC:
// FSM states, default widths and the radix-4 Booth digit encoding.
package mac_pkg;

   localparam int MAC_DATA_WIDTH = 16;
   localparam int MAC_OUT_WIDTH  = 32;
   localparam int MAC_LEN_WIDTH  = 8;
   localparam int ITER           = MAC_DATA_WIDTH / 2;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_MULT = 3'd2,
      S_ACC  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      DIG_ZERO = 3'b000,
      DIG_POS1 = 3'b001,
      DIG_POS2 = 3'b010,
      DIG_NEG1 = 3'b101,
      DIG_NEG2 = 3'b110
   } digit_t;

   // Radix-4 Booth recoding of {b[2i+1], b[2i], b[2i-1]}
   function automatic digit_t booth_digit(input logic [2:0] trip);
      digit_t d;
      case (trip)
         3'b001, 3'b010: d = DIG_POS1;
         3'b011:         d = DIG_POS2;
         3'b100:         d = DIG_NEG2;
         3'b101, 3'b110: d = DIG_NEG1;
         default:        d = DIG_ZERO;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mac_dot_seq_if.sv
// Job request, operand stream and result bundle for mac_dot_seq.
interface mac_dot_seq_if
   import mac_pkg::*;
#(
   parameter int DATA_WIDTH = MAC_DATA_WIDTH,
   parameter int OUT_WIDTH  = MAC_OUT_WIDTH,
   parameter int LEN_WIDTH  = MAC_LEN_WIDTH
);
   logic                         start;
   logic [LEN_WIDTH-1:0]         len;
   logic                         busy;
   logic                         in_valid;
   logic                         in_ready;
   logic signed [DATA_WIDTH-1:0] a;
   logic signed [DATA_WIDTH-1:0] b;
   logic signed [OUT_WIDTH-1:0]  out;
   logic                         out_valid;
   logic                         ovf;

   modport master (
      output start, len, in_valid, a, b,
      input  busy, in_ready, out, out_valid, ovf
   );

   modport slave (
      input  start, len, in_valid, a, b,
      output busy, in_ready, out, out_valid, ovf
   );
endinterface

// File: rtl/mac_dot_seq_booth.sv
// Sequential radix-4 Booth multiplier: the go edge retires digit 0 directly
// from a/b, then one digit per cycle; done pulses once the product is final.
module booth_r4_seq
   import mac_pkg::*;
#(
   parameter int DATA_WIDTH = MAC_DATA_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           go,
   input  logic signed [DATA_WIDTH-1:0]   a,
   input  logic signed [DATA_WIDTH-1:0]   b,
   output logic                           done,
   output logic signed [2*DATA_WIDTH-1:0] product
);
   localparam int STEPS = DATA_WIDTH / 2;
   localparam int PW    = 2 * DATA_WIDTH;
   localparam int CW    = $clog2(STEPS + 1);

   logic signed [DATA_WIDTH-1:0] mcand_r, mc_s;
   logic signed [DATA_WIDTH:0]   mplier_r, mp_s;
   logic signed [DATA_WIDTH+1:0] pp_s;
   logic signed [PW-1:0]         prod_r, base_s, pp_ext_s, sum_s;
   logic [CW-1:0]                cnt_r, idx_s;
   logic                         running_r, done_r;

   function automatic logic signed [DATA_WIDTH+1:0] booth_pp(
      input digit_t d, input logic signed [DATA_WIDTH-1:0] m);
      logic signed [DATA_WIDTH+1:0] m1, r;
      m1 = {{2{m[DATA_WIDTH-1]}}, m};
      case (d)
         DIG_POS1: r = m1;
         DIG_NEG1: r = -m1;
         DIG_POS2: r = m1 <<< 1;
         DIG_NEG2: r = -(m1 <<< 1);
         default:  r = '0;
      endcase
      return r;
   endfunction

   // Select this cycle's digit and partial-product sum
   always_comb begin
      mc_s     = go ? a : mcand_r;
      mp_s     = go ? {b, 1'b0} : mplier_r;
      base_s   = go ? '0 : prod_r;
      idx_s    = go ? '0 : cnt_r;
      pp_s     = booth_pp(booth_digit(mp_s[2:0]), mc_s);
      pp_ext_s = PW'(pp_s);
      sum_s    = base_s + (pp_ext_s <<< {idx_s, 1'b0});
   end

   // Digit iteration, product register and done pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_r   <= '0;
         mplier_r  <= '0;
         prod_r    <= '0;
         cnt_r     <= '0;
         running_r <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (go) begin
            mcand_r   <= a;
            mplier_r  <= mp_s >>> 2;
            prod_r    <= sum_s;
            cnt_r     <= CW'(1);
            running_r <= (STEPS > 1);
            done_r    <= (STEPS == 1);
         end else if (running_r) begin
            mplier_r <= mp_s >>> 2;
            prod_r   <= sum_s;
            cnt_r    <= cnt_r + CW'(1);
            if (cnt_r == CW'(STEPS - 1)) begin
               running_r <= 1'b0;
               done_r    <= 1'b1;
            end
         end
      end
   end

   assign done    = done_r;
   assign product = prod_r;
endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: accepts a job, pulls len operand pairs, accumulates
// Booth products with sticky signed-overflow detection and strobes the result.
module mac_dot_seq
   import mac_pkg::*;
#(
   parameter int DATA_WIDTH = MAC_DATA_WIDTH,
   parameter int OUT_WIDTH  = MAC_OUT_WIDTH,
   parameter int LEN_WIDTH  = MAC_LEN_WIDTH
) (
   input logic          clk,
   input logic          rst,
   mac_dot_seq_if.slave bus
);
   state_t                         state_r;
   logic [LEN_WIDTH-1:0]           remaining_r;
   logic signed [OUT_WIDTH-1:0]    acc_r, out_r, prod_ext_s, sum_s;
   logic                           ovf_acc_r, ovf_r, out_valid_r, busy_r;
   logic                           ov_s, go_s, core_done_s;
   logic signed [2*DATA_WIDTH-1:0] product_s;

   assign go_s = bus.in_valid && (state_r == S_LOAD);

   booth_r4_seq #(.DATA_WIDTH(DATA_WIDTH)) u_booth (
      .clk     (clk),
      .rst     (rst),
      .go      (go_s),
      .a       (bus.a),
      .b       (bus.b),
      .done    (core_done_s),
      .product (product_s)
   );

   // Wrapping accumulate and two's-complement overflow detect
   always_comb begin
      prod_ext_s = OUT_WIDTH'(product_s);
      sum_s      = acc_r + prod_ext_s;
      ov_s       = (acc_r[OUT_WIDTH-1] == prod_ext_s[OUT_WIDTH-1]) &&
                   (sum_s[OUT_WIDTH-1] != acc_r[OUT_WIDTH-1]);
   end

   // Job sequencing FSM; result and flag are loaded on entry to DONE so they
   // line up with the out_valid strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= S_IDLE;
         remaining_r <= '0;
         acc_r       <= '0;
         ovf_acc_r   <= 1'b0;
         out_r       <= '0;
         ovf_r       <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         out_valid_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (bus.start) begin
                  remaining_r <= bus.len;
                  acc_r       <= '0;
                  ovf_acc_r   <= 1'b0;
                  busy_r      <= 1'b1;
                  if (bus.len != '0) begin
                     state_r <= S_LOAD;
                  end else begin
                     state_r     <= S_DONE;
                     out_r       <= '0;
                     ovf_r       <= 1'b0;
                     out_valid_r <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (bus.in_valid) state_r <= S_MULT;
            end
            S_MULT: begin
               if (core_done_s) state_r <= S_ACC;
            end
            S_ACC: begin
               acc_r       <= sum_s;
               ovf_acc_r   <= ovf_acc_r | ov_s;
               remaining_r <= remaining_r - LEN_WIDTH'(1);
               if (remaining_r == LEN_WIDTH'(1)) begin
                  state_r     <= S_DONE;
                  out_r       <= sum_s;
                  ovf_r       <= ovf_acc_r | ov_s;
                  out_valid_r <= 1'b1;
               end else begin
                  state_r <= S_LOAD;
               end
            end
            S_DONE: begin
               state_r <= S_IDLE;
               busy_r  <= 1'b0;
            end
            default: state_r <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state_r == S_LOAD);
   assign bus.busy      = busy_r;
   assign bus.out       = out_r;
   assign bus.out_valid = out_valid_r;
   assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq: jobs push expected results into a
// scoreboard queue, a negedge monitor pops and compares on out_valid.
module tb_mac_dot_seq;
   import mac_pkg::*;

   localparam int PAIR_CYC = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mac_dot_seq_if bus ();
   mac_dot_seq dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int out_v;
      bit ovf_v;
      int lat;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   vectors     = 0;
   int   miscompares = 0;
   int   done_cnt    = 0;
   int   job_t0      = 0;
   bit   chk_drop    = 1'b0;
   int   pa[4];
   int   pb[4];

   task automatic check(input string name, input longint act, input longint exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (chk_drop) begin
            check("busy_drop", longint'(bus.busy), 0);
            chk_drop <= 1'b0;
         end
         if (bus.out_valid) begin
            if (sb_q.size() == 0) begin
               check("spurious_out_valid", 1, 0);
            end else begin
               mon_e = sb_q.pop_front();
               check("out", longint'(bus.out), longint'(mon_e.out_v));
               check("ovf", longint'(bus.ovf), longint'(mon_e.ovf_v));
               if (mon_e.lat >= 0) check("latency", longint'(cyc - job_t0), longint'(mon_e.lat));
               check("busy_at_done", longint'(bus.busy), 1);
            end
            chk_drop <= 1'b1;
            done_cnt <= done_cnt + 1;
         end
      end
   end

   task automatic set_pairs(input int a0, input int b0, input int a1, input int b1,
                            input int a2, input int b2);
      pa[0] = a0; pb[0] = b0;
      pa[1] = a1; pb[1] = b1;
      pa[2] = a2; pb[2] = b2;
      pa[3] = 0;  pb[3] = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},      longint'(bus.busy), 0);
      check({tag, "_in_ready"},  longint'(bus.in_ready), 0);
      check({tag, "_out_valid"}, longint'(bus.out_valid), 0);
      check({tag, "_ovf"},       longint'(bus.ovf), 0);
      check({tag, "_out"},       longint'(bus.out), 0);
   endtask

   task automatic run_job(input int n, input int exp_out, input bit exp_ovf,
                          input bit gaps, input bit poke, input int abort);
      int  base;
      int  lows;
      bit  got;
      base = done_cnt;
      if (abort < 0) sb_q.push_back('{exp_out, exp_ovf, gaps ? -1 : n * PAIR_CYC});
      @(negedge clk);
      bus.start = 1'b1;
      bus.len   = 8'(n);
      @(posedge clk);
      #1 job_t0 = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      for (int p = 0; p < n; p++) begin
         if (gaps) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
         bus.a        = 16'(pa[p]);
         bus.b        = 16'(pb[p]);
         bus.in_valid = 1'b1;
         got = 1'b0;
         for (int w = 0; w < 100; w++) begin
            if (bus.in_ready) begin
               got = 1'b1;
               break;
            end
            @(negedge clk);
         end
         check("handshake_seen", longint'(got), 1);
         if (!got) return;
         @(negedge clk);
         if (gaps || p == n - 1) bus.in_valid = 1'b0;
         if (p == abort) begin
            repeat (3) @(negedge clk);
            #2 rst = 1'b1;
            #1 check_reset_outputs("abort");
            repeat (2) @(negedge clk);
            bus.in_valid = 1'b0;
            rst = 1'b0;
            return;
         end
         if (!gaps && p < n - 1) begin
            lows = 0;
            for (int w = 0; w < 50; w++) begin
               if (bus.in_ready) break;
               lows++;
               if (poke && p == 0 && lows == 2) begin
                  bus.start = 1'b1;
                  bus.len   = 8'd5;
               end
               if (poke && p == 0 && lows == 3) bus.start = 1'b0;
               @(negedge clk);
            end
            check("in_ready_low_cycles", longint'(lows), longint'(PAIR_CYC - 1));
         end
      end
      bus.in_valid = 1'b0;
      for (int w = 0; w < 300; w++) begin
         if (done_cnt != base) break;
         @(negedge clk);
      end
      check("job_done", longint'(done_cnt - base), 1);
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.len      = 8'd0;
      bus.in_valid = 1'b0;
      bus.a        = 16'sd0;
      bus.b        = 16'sd0;
      #12 check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      set_pairs(15, 5, 0, 0, 0, 0);
      run_job(1, 75, 1'b0, 1'b0, 1'b0, -1);

      set_pairs(15, 5, 10, 29, 7, 5);
      run_job(3, 400, 1'b0, 1'b0, 1'b1, -1);
      repeat (20) @(negedge clk);
      check("out_held", longint'(bus.out), 400);
      check("idle_busy", longint'(bus.busy), 0);

      set_pairs(3, -2, -6, 6, -2, -2);
      run_job(3, -38, 1'b0, 1'b0, 1'b0, -1);

      set_pairs(-32768, -32768, 0, 0, 0, 0);
      run_job(1, 1073741824, 1'b0, 1'b0, 1'b0, -1);

      set_pairs(-32768, -32768, -32768, -32768, 0, 0);
      run_job(2, int'(32'h8000_0000), 1'b1, 1'b0, 1'b0, -1);

      set_pairs(1, 1, 0, 0, 0, 0);
      run_job(1, 1, 1'b0, 1'b0, 1'b0, -1);

      run_job(0, 0, 1'b0, 1'b0, 1'b0, -1);

      set_pairs(100, -200, -300, -400, 32767, 32767);
      run_job(3, 1073776289, 1'b0, 1'b1, 1'b0, -1);

      set_pairs(5, 6, 7, 8, 9, 10);
      run_job(3, 0, 1'b0, 1'b0, 1'b0, 1);
      repeat (30) @(negedge clk);
      check("post_abort_out", longint'(bus.out), 0);
      check("post_abort_busy", longint'(bus.busy), 0);

      set_pairs(-7, 9, 12, -3, 0, 0);
      run_job(2, -99, 1'b0, 1'b0, 1'b0, -1);

      repeat (5) @(negedge clk);
      check("scoreboard_empty", longint'(sb_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule
